// File: rtl/shadoks_sdram_pkg.sv
// Shared types and default constants for the Shadoks SDRAM refresh logic.
package shadoks_sdram_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_REQ  = 2'd2,
    S_BUSY = 2'd3
  } state_t;

  // 15 us at 24 MHz keeps 4096 rows inside 64 ms with margin.
  localparam int DEF_REFRESH_INTERVAL = 360;
  localparam int DEF_MAX_OWED         = 8;
  localparam int DEF_URGENT_LEVEL     = 4;
  localparam int DEF_BUSY_TIMEOUT     = 63;

endpackage

// File: rtl/refresh_tick_timer.sv
// Free-running down-counter; tick is high on the cycle the count reads zero.
module refresh_tick_timer
  import shadoks_sdram_pkg::*;
#(
  parameter int INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)            cnt <= CW'(INTERVAL - 1);
    else if (cnt == '0)   cnt <= CW'(INTERVAL - 1);
    else                  cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/sdram_refresh_scheduler.sv
// Refresh debt tracker and request FSM that slots auto-refresh into bus-quiet windows.
// Optional REFRESH_STATS_EN adds grant counters split by launch type.
module sdram_refresh_scheduler
  import shadoks_sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int MAX_OWED         = DEF_MAX_OWED,
  parameter int URGENT_LEVEL     = DEF_URGENT_LEVEL,
  parameter int BUSY_TIMEOUT     = DEF_BUSY_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        access_slot,
  input  logic        vu_pending,
  input  logic        disk_pending,
  output logic        refresh_req,
  input  logic        refresh_grant,
  input  logic        sdram_busy,
  output logic [3:0]  owed,
  output logic        urgent,
  output logic        error
`ifdef REFRESH_STATS_EN
  ,
  output logic [15:0] stat_opport,
  output logic [15:0] stat_forced
`endif
);

  localparam int BCW = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;

  state_t         state, state_nxt;
  logic           tick;
  logic           grant_ok, bad_grant, overflow, busy_fire, busy_to;
  logic           opp_launch, forced_launch;
  logic [BCW-1:0] busy_cnt;

  refresh_tick_timer #(.INTERVAL(REFRESH_INTERVAL)) u_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign urgent        = (owed >= 4'(URGENT_LEVEL));
  assign opp_launch    = access_slot & ~vu_pending & ~disk_pending;
  assign forced_launch = urgent & ~vu_pending;
  // Only a grant answering our own request counts; anything else is a protocol fault.
  assign grant_ok      = refresh_grant & (state == S_REQ);
  assign bad_grant     = refresh_grant & (state != S_REQ);
  assign overflow      = tick & ~grant_ok & (owed == 4'(MAX_OWED));
  assign busy_to       = (busy_cnt == BCW'(BUSY_TIMEOUT));
  assign busy_fire     = (state == S_BUSY) & sdram_busy & busy_to;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    refresh_req = 1'b0;
    case (state)
      S_IDLE: if (owed != '0) state_nxt = S_ARM;
      S_ARM: begin
        if (owed == '0)                        state_nxt = S_IDLE;
        else if (opp_launch || forced_launch)  state_nxt = S_REQ;
      end
      S_REQ: begin
        refresh_req = 1'b1;
        // A grant racing a VU preemption wins: the command is already out.
        if (refresh_grant)   state_nxt = S_BUSY;
        else if (vu_pending) state_nxt = S_ARM;
      end
      S_BUSY: begin
        if (!sdram_busy)  state_nxt = (owed != '0) ? S_ARM : S_IDLE;
        else if (busy_to) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owed <= '0;
    end else begin
      case ({tick, grant_ok})
        2'b10:   if (owed != 4'(MAX_OWED)) owed <= owed + 1'b1;
        2'b01:   if (owed != '0)           owed <= owed - 1'b1;
        default: owed <= owed;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                              error <= 1'b0;
    else if (overflow | bad_grant | busy_fire) error <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || state != S_BUSY) busy_cnt <= '0;
    else if (!busy_to)            busy_cnt <= busy_cnt + 1'b1;
  end

`ifdef REFRESH_STATS_EN
  logic launch_forced;

  // Opportunistic takes precedence when both launch conditions hold.
  always_ff @(posedge clk) begin
    if (reset)
      launch_forced <= 1'b0;
    else if (state == S_ARM && owed != '0 && (opp_launch || forced_launch))
      launch_forced <= ~opp_launch;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_opport <= '0;
      stat_forced <= '0;
    end else if (grant_ok) begin
      if (launch_forced && stat_forced != 16'hFFFF)      stat_forced <= stat_forced + 1'b1;
      else if (!launch_forced && stat_opport != 16'hFFFF) stat_opport <= stat_opport + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// Scoreboard bench for sdram_refresh_scheduler: expectations queued with stimulus, checked at their cycle.
module tb_sdram_refresh_scheduler;

  logic clk = 1'b0, reset = 1'b1;
  logic access_slot = 1'b0, vu_pending = 1'b0, disk_pending = 1'b0;
  logic refresh_grant = 1'b0, sdram_busy = 1'b0;
  logic refresh_req, urgent, error;
  logic [3:0] owed;
`ifdef REFRESH_STATS_EN
  logic [15:0] stat_opport, stat_forced;
`endif

  always #5 clk = ~clk;

  sdram_refresh_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .access_slot   (access_slot),
    .vu_pending    (vu_pending),
    .disk_pending  (disk_pending),
    .refresh_req   (refresh_req),
    .refresh_grant (refresh_grant),
    .sdram_busy    (sdram_busy),
    .owed          (owed),
    .urgent        (urgent),
    .error         (error)
`ifdef REFRESH_STATS_EN
    ,
    .stat_opport   (stat_opport),
    .stat_forced   (stat_forced)
`endif
  );

  typedef struct {
    int          cyc;
    string       what;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n, n_chk, n_fail, busy_left, slot_per, grants;
  bit   arb_en, granted_now;

  function automatic logic [31:0] observe(string what);
    if (what == "owed") return {28'd0, owed};
    if (what == "req")  return {31'd0, refresh_req};
    if (what == "urg")  return {31'd0, urgent};
    if (what == "err")  return {31'd0, error};
`ifdef REFRESH_STATS_EN
    if (what == "sopp") return {16'd0, stat_opport};
    if (what == "sfrc") return {16'd0, stat_forced};
`endif
    return 32'hDEAD_BEEF;
  endfunction

  // One clock; emulates the arbiter (grant 1 clock after req, busy 6 clocks) when enabled.
  task automatic step();
    bit prev_g;
    @(posedge clk); #1;
    n++;
    prev_g        = refresh_grant;
    access_slot   = 1'b0;
    refresh_grant = 1'b0;
    granted_now   = 1'b0;
    if (busy_left > 0) busy_left--;
    sdram_busy = (busy_left > 0);
    if (slot_per > 0 && n % slot_per == 0) access_slot = 1'b1;
    if (arb_en && refresh_req === 1'b1 && !prev_g) begin
      refresh_grant = 1'b1;
      busy_left     = 6;
      sdram_busy    = 1'b1;
      grants++;
      granted_now   = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; access_slot = 1'b0; vu_pending = 1'b0; disk_pending = 1'b0;
    refresh_grant = 1'b0; sdram_busy = 1'b0;
    busy_left = 0; slot_per = 0; arb_en = 1'b0; grants = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; access_slot = 1'b1; refresh_grant = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n = 0;
    sb.push_back('{0, "req", 0});
    sb.push_back('{0, "owed", 0});
    sb.push_back('{0, "urg", 0});
    sb.push_back('{0, "err", 0});
    while (sb.size() > 0 && sb[0].cyc <= n) begin
      e = sb.pop_front(); n_chk++;
      if (observe(e.what) !== e.val) begin n_fail++; $display("FAIL reset/%s @%0d: got %0d want %0d", e.what, n, observe(e.what), e.val); end
    end
  endtask

  task automatic test_first_tick();
    do_reset();
    sb.push_back('{359, "owed", 0});
    sb.push_back('{360, "owed", 1});
    sb.push_back('{360, "urg", 0});
    sb.push_back('{365, "req", 0});
    while (n < 366) begin
      step();
      while (sb.size() > 0 && sb[0].cyc <= n) begin
        e = sb.pop_front(); n_chk++;
        if (observe(e.what) !== e.val) begin n_fail++; $display("FAIL tick/%s @%0d: got %0d want %0d", e.what, n, observe(e.what), e.val); end
      end
    end
  endtask

  task automatic test_opportunistic();
    int tq[$];
    int t, maxo;
    maxo = 0;
    do_reset();
    slot_per = 20; arb_en = 1'b1;
    while (n < 1480) begin
      step();
      if (n % 360 == 0) tq.push_back(n);
      if (int'(owed) > maxo) maxo = int'(owed);
      if (granted_now) begin
        n_chk++;
        if (tq.size() == 0) begin
          n_fail++; $display("FAIL opp_grant @%0d: got grant with no tick owed, want none", n);
        end else begin
          t = tq.pop_front();
          if (n - t <= 0 || n - t >= 360) begin n_fail++; $display("FAIL opp_grant @%0d: got lag %0d want 1..359", n, n - t); end
        end
      end
    end
    n_chk++; if (tq.size() != 0) begin n_fail++; $display("FAIL opp_unserved: got %0d ticks unserved want 0", tq.size()); end
    n_chk++; if (grants != 4) begin n_fail++; $display("FAIL opp_count: got %0d grants want 4", grants); end
    n_chk++; if (maxo != 1) begin n_fail++; $display("FAIL opp_maxowed: got %0d want 1", maxo); end
    n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL opp_err: got %b want 0", error); end
  endtask

  task automatic test_forced();
    do_reset();
    disk_pending = 1'b1;
    sb.push_back('{1439, "owed", 3});
    sb.push_back('{1439, "urg", 0});
    sb.push_back('{1440, "owed", 4});
    sb.push_back('{1440, "urg", 1});
    sb.push_back('{1440, "req", 0});
    sb.push_back('{1441, "req", 1});
    sb.push_back('{1460, "owed", 3});
    sb.push_back('{1460, "err", 0});
    while (n < 1460) begin
      step();
      if (n == 1442) arb_en = 1'b1;
      while (sb.size() > 0 && sb[0].cyc <= n) begin
        e = sb.pop_front(); n_chk++;
        if (observe(e.what) !== e.val) begin n_fail++; $display("FAIL forced/%s @%0d: got %0d want %0d", e.what, n, observe(e.what), e.val); end
      end
    end
  endtask

  task automatic test_vu_preempt();
    do_reset();
    while (n < 400) begin
      step();
      case (n)
        370: begin access_slot = 1'b1; sb.push_back('{371, "req", 1}); end
        371: begin vu_pending = 1'b1;  sb.push_back('{372, "req", 0}); end
        374: begin access_slot = 1'b1; sb.push_back('{375, "req", 0}); end
        376: vu_pending = 1'b0;
        380: begin access_slot = 1'b1; sb.push_back('{380, "req", 0}); sb.push_back('{381, "req", 1}); end
        381: begin arb_en = 1'b1; sb.push_back('{395, "owed", 0}); end
        default: ;
      endcase
      while (sb.size() > 0 && sb[0].cyc <= n) begin
        e = sb.pop_front(); n_chk++;
        if (observe(e.what) !== e.val) begin n_fail++; $display("FAIL vu/%s @%0d: got %0d want %0d", e.what, n, observe(e.what), e.val); end
      end
    end
  endtask

  task automatic test_grant_outside();
    do_reset();
    while (n < 14) begin
      step();
      if (n == 10) begin refresh_grant = 1'b1; sb.push_back('{11, "err", 1}); sb.push_back('{11, "owed", 0}); end
      while (sb.size() > 0 && sb[0].cyc <= n) begin
        e = sb.pop_front(); n_chk++;
        if (observe(e.what) !== e.val) begin n_fail++; $display("FAIL stray/%s @%0d: got %0d want %0d", e.what, n, observe(e.what), e.val); end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    vu_pending = 1'b1;
    sb.push_back('{2880, "owed", 8});
    sb.push_back('{2880, "err", 0});
    sb.push_back('{3239, "err", 0});
    sb.push_back('{3240, "err", 1});
    sb.push_back('{3240, "owed", 8});
    sb.push_back('{3600, "owed", 8});
    sb.push_back('{3660, "err", 1});
    while (n < 3660) begin
      step();
      if (n == 3600) begin vu_pending = 1'b0; arb_en = 1'b1; end
      while (sb.size() > 0 && sb[0].cyc <= n) begin
        e = sb.pop_front(); n_chk++;
        if (observe(e.what) !== e.val) begin n_fail++; $display("FAIL sat/%s @%0d: got %0d want %0d", e.what, n, observe(e.what), e.val); end
      end
    end
    do_reset();
    sb.push_back('{0, "err", 0});
    while (sb.size() > 0 && sb[0].cyc <= n) begin
      e = sb.pop_front(); n_chk++;
      if (observe(e.what) !== e.val) begin n_fail++; $display("FAIL sat_clr/%s @%0d: got %0d want %0d", e.what, n, observe(e.what), e.val); end
    end
  endtask

  task automatic test_tick_grant_and_timeout();
    do_reset();
    vu_pending = 1'b1;
    while (n < 1512) begin
      step();
      case (n)
        1437: vu_pending = 1'b0;
        1438: begin
          access_slot = 1'b1;
          sb.push_back('{1439, "req", 1}); sb.push_back('{1439, "owed", 3});
        end
        1439: begin
          refresh_grant = 1'b1; busy_left = 70; sdram_busy = 1'b1;
          sb.push_back('{1440, "owed", 3}); sb.push_back('{1440, "req", 0});
          sb.push_back('{1441, "owed", 3});
          sb.push_back('{1503, "err", 0});  sb.push_back('{1504, "err", 1});
        end
        1505: begin access_slot = 1'b1; sb.push_back('{1506, "req", 1}); end
        default: ;
      endcase
      while (sb.size() > 0 && sb[0].cyc <= n) begin
        e = sb.pop_front(); n_chk++;
        if (observe(e.what) !== e.val) begin n_fail++; $display("FAIL tgt/%s @%0d: got %0d want %0d", e.what, n, observe(e.what), e.val); end
      end
    end
  endtask

`ifdef REFRESH_STATS_EN
  task automatic test_stats();
    do_reset();
    slot_per = 20; arb_en = 1'b1;
    sb.push_back('{1110, "sopp", 3});
    sb.push_back('{1110, "sfrc", 0});
    sb.push_back('{2920, "sopp", 3});
    sb.push_back('{2920, "sfrc", 2});
    while (n < 2920) begin
      step();
      if (n == 1110) begin slot_per = 0; vu_pending = 1'b1; end
      if (n == 2882) begin vu_pending = 1'b0; disk_pending = 1'b1; end
      while (sb.size() > 0 && sb[0].cyc <= n) begin
        e = sb.pop_front(); n_chk++;
        if (observe(e.what) !== e.val) begin n_fail++; $display("FAIL stats/%s @%0d: got %0d want %0d", e.what, n, observe(e.what), e.val); end
      end
    end
  endtask
`endif

  initial begin
    n_chk = 0; n_fail = 0;
    test_reset();
    test_first_tick();
    test_opportunistic();
    test_forced();
    test_vu_preempt();
    test_grant_outside();
    test_saturation();
    test_tick_grant_and_timeout();
`ifdef REFRESH_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdram_refresh_scheduler.md
# sdram_refresh_scheduler

Schedules SDRAM auto-refresh for the Shadoks expansion board so refresh cycles land in Vector-06c bus-quiet slots instead of colliding with КВАЗ accesses. The block runs on `clk_cpu` (24 MHz) beside `sdram_arbitre`. It keeps a count of owed refreshes from a fixed-interval timer and asks the arbiter for refresh opportunistically in free access slots. When the debt grows too large it forces the request regardless of slot.

## Interface
Parameters:
- `REFRESH_INTERVAL`, 360: clocks between refresh ticks (15 µs at 24 MHz; 4096 rows / 64 ms with margin).
- `MAX_OWED`, 8: saturation value of the owed counter (4-bit field).
- `URGENT_LEVEL`, 4: owed count at or above which requests ignore `access_slot`.
- `BUSY_TIMEOUT`, 63: maximum clocks allowed in BUSY before the error flag is set.

Ports:
- `clk` in 1: `clk_cpu`. One clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high (`sys_reset`).
- `access_slot` in 1: one-cycle pulse marking a bus-quiet window (`posedge_ras_n & ccas_n & VU_BLK_N`).
- `vu_pending` in 1: arbiter holds an unserved КВАЗ read/write.
- `disk_pending` in 1: arbiter holds an unserved floppy access.
- `refresh_req` out 1: level request to the arbiter.
- `refresh_grant` in 1: one-cycle pulse from the arbiter when the refresh command is launched.
- `sdram_busy` in 1: `ramc_busy`.
- `owed` out 4: current refresh debt.
- `urgent` out 1: `owed >= URGENT_LEVEL`.
- `error` out 1: sticky; set on owed overflow or BUSY timeout.

## Operation
- Tick timer: counts `REFRESH_INTERVAL-1` down to 0, then reloads. It emits a `tick` on the 0 cycle. The timer runs free regardless of the FSM.
- Owed counter updates:
  - `tick` alone: +1.
  - `refresh_grant` alone: −1.
  - Both in the same cycle: unchanged.
  - `tick` at `owed==MAX_OWED`: stays at MAX_OWED and sets `error`.
  - `refresh_grant` at `owed==0`: ignored.
- FSM states:
  - IDLE: waits until `owed != 0`, then goes to ARM.
  - ARM: waits for a launch condition.
    - Opportunistic launch: `access_slot & ~vu_pending & ~disk_pending`.
    - Forced launch: `urgent & ~vu_pending`. This ignores `access_slot` and `disk_pending`.
    - On either condition, go to REQ.
    - If `owed` drops to 0, return to IDLE.
  - REQ: `refresh_req=1` until `refresh_grant`, then go to BUSY.
    - VU always wins: if `vu_pending` rises while in REQ, deassert `refresh_req` and return to ARM (the arbiter has not granted yet).
  - BUSY: wait for `sdram_busy` to fall.
    - Then go to IDLE, or directly to ARM if `owed != 0`.
    - BUSY longer than `BUSY_TIMEOUT` clocks: set `error` and return to IDLE.
- `urgent` is combinational from `owed`.

## Timing
- Reset values: `refresh_req=0`, `owed=0`, `urgent=0`, `error=0`, FSM=IDLE, timer=`REFRESH_INTERVAL-1`.
- Reset is honoured in any state. A refresh already in flight is abandoned, and the SDRAM controller completes it on its own.
- First `tick` arrives `REFRESH_INTERVAL` clocks after reset deassertion.
- Launch latency:
  - `refresh_req` rises 1 clock after the launch condition is sampled in ARM.
  - It falls the clock after `refresh_grant`.
- `owed` updates the clock after `tick` or `refresh_grant`.
- A grant in the same cycle as a VU preemption counts as a grant: go to BUSY, do not drop back to ARM.
- `refresh_grant` seen outside REQ is ignored and sets `error`.

## Configuration
- `REFRESH_STATS_EN` defined:
  - Adds outputs `stat_opport` [15:0] and `stat_forced` [15:0], counting grants that followed an opportunistic or a forced launch.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `shadoks_sdram_pkg`:
  - FSM state encodings: IDLE=0, ARM=1, REQ=2, BUSY=3.
  - Default constants: interval, owed limit, urgency level, timeout.
- Sub-module `refresh_tick_timer` (parameter `INTERVAL`; ports `clk`, `reset`, `tick`) holds the free-running down-counter.

## Test plan
- Idle bus, `access_slot` pulsed every 20 clocks, arbiter grants 1 clock after `refresh_req`, `sdram_busy` high for 6 clocks → exactly one grant per 360 clocks, `owed` never exceeds 1, `error=0`.
- No `access_slot` for 1500 clocks → `owed` reaches 4 at about clock 1440 and `urgent=1`. `refresh_req` rises 1 clock later despite `disk_pending=1`.
- `vu_pending` asserted while in REQ → `refresh_req` drops the next clock. It reasserts on the next qualifying slot after `vu_pending` falls.
- Grants withheld for 9×360 clocks → `owed` saturates at 8 and `error` is set sticky. It clears only on `reset`.
- `tick` and `refresh_grant` in the same cycle with `owed=3` → `owed` stays 3. `sdram_busy` held for 70 clocks → `error` set, FSM returns to IDLE.
- With `REFRESH_STATS_EN`: 3 opportunistic grants plus 2 forced grants → `stat_opport=3`, `stat_forced=2`.
